// File: rtl/inst_loader.sv
// Boot loader for the instruction RAM write port: packs a byte stream into
// big-endian words, writes them from address 0 and holds the core off meanwhile.
module inst_loader #(
    parameter int DEPTH   = 128,
    parameter int TIMEOUT = 1023,
    parameter int SETTLE  = 2,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    load_words,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic          IWEN,
    output logic [AW-1:0] I_Addr,
    output logic [31:0]   wInst,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [7:0]    checksum
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(SETTLE + 1);
    localparam logic [7:0]    DMAX  = 8'(DEPTH);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
    localparam logic [SW-1:0] SLAST = SW'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t        state, state_n;
    logic          iwen_n, busy_n, done_n, error_n;
    logic [AW-1:0] addr_n;
    logic [31:0]   winst_n;
    logic [7:0]    csum_n;
    logic [23:0]   pack, pack_n;
    logic [1:0]    bidx, bidx_n;
    logic [7:0]    widx, widx_n;
    logic [7:0]    nwords, nwords_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [SW-1:0] scnt, scnt_n;
    logic          xfer;
    logic          words_ok;

    assign rx_ready = (state == S_LOAD);
    assign xfer     = rx_valid & rx_ready;
    assign words_ok = (load_words != 8'd0) && (load_words <= DMAX);

    always_comb begin
        state_n  = state;
        iwen_n   = IWEN;
        busy_n   = busy;
        done_n   = done;
        error_n  = error;
        addr_n   = I_Addr;
        winst_n  = wInst;
        csum_n   = checksum;
        pack_n   = pack;
        bidx_n   = bidx;
        widx_n   = widx;
        nwords_n = nwords;
        tcnt_n   = tcnt;
        scnt_n   = scnt;
        unique case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start && words_ok) begin
                    state_n  = S_LOAD;
                    iwen_n   = 1'b1;
                    busy_n   = 1'b1;
                    done_n   = 1'b0;
                    error_n  = 1'b0;
                    addr_n   = '0;
                    winst_n  = '0;
                    csum_n   = '0;
                    pack_n   = '0;
                    bidx_n   = '0;
                    widx_n   = '0;
                    tcnt_n   = '0;
                    scnt_n   = '0;
                    nwords_n = load_words;
                end else if (start) begin
                    state_n = S_ERROR;
                    done_n  = 1'b0;
                    error_n = 1'b1;
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    csum_n = checksum + rx_data;
                    tcnt_n = '0;
                    bidx_n = bidx + 2'd1;
                    pack_n = {pack[15:0], rx_data};
                    // only whole words ever reach wInst
                    if (bidx == 2'd3) begin
                        winst_n = {pack, rx_data};
                        addr_n  = widx[AW-1:0];
                        widx_n  = widx + 8'd1;
                        if (widx == nwords - 8'd1) begin
                            state_n = S_SETTLE;
                            scnt_n  = '0;
                        end
                    end
                end else if (tcnt == TLAST) begin
                    state_n = S_ERROR;
                    iwen_n  = 1'b0;
                    busy_n  = 1'b0;
                    error_n = 1'b1;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            S_SETTLE: begin
                if (scnt == SLAST) begin
                    state_n = S_DONE;
                    iwen_n  = 1'b0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else begin
                    scnt_n = scnt + 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                iwen_n  = 1'b0;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            IWEN     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            I_Addr   <= '0;
            wInst    <= '0;
            checksum <= '0;
            pack     <= '0;
            bidx     <= '0;
            widx     <= '0;
            nwords   <= '0;
            tcnt     <= '0;
            scnt     <= '0;
        end else begin
            state    <= state_n;
            IWEN     <= iwen_n;
            busy     <= busy_n;
            done     <= done_n;
            error    <= error_n;
            I_Addr   <= addr_n;
            wInst    <= winst_n;
            checksum <= csum_n;
            pack     <= pack_n;
            bidx     <= bidx_n;
            widx     <= widx_n;
            nwords   <= nwords_n;
            tcnt     <= tcnt_n;
            scnt     <= scnt_n;
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Bench for inst_loader: per-cycle comparison against a byte-list model
// plus directed literal checks.
module tb_inst_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  load_words = 8'd0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        IWEN;
    logic [6:0]  I_Addr;
    logic [31:0] wInst;
    logic        busy;
    logic        done;
    logic        error;
    logic [7:0]  checksum;

    int n_vec = 0;
    int n_bad = 0;

    inst_loader dut (
        .clk(clk), .rst(rst), .start(start), .load_words(load_words),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .IWEN(IWEN), .I_Addr(I_Addr), .wInst(wInst), .busy(busy),
        .done(done), .error(error), .checksum(checksum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // model: phase 0 idle, 1 load, 2 settle, 3 done, 4 error
    int          m_phase;
    logic [7:0]  m_bytes[$];
    int          m_words, m_idle, m_settle;
    logic        e_iwen, e_busy, e_done, e_error;
    logic [6:0]  e_addr;
    logic [31:0] e_winst;
    logic [7:0]  e_csum;

    task automatic model_reset();
        m_phase = 0; m_bytes.delete(); m_words = 0; m_idle = 0; m_settle = 0;
        e_iwen = 0; e_busy = 0; e_done = 0; e_error = 0;
        e_addr = '0; e_winst = '0; e_csum = '0;
    endtask

    task automatic model_step();
        int k;
        int s;
        case (m_phase)
            0, 3, 4: if (start) begin
                if (load_words >= 1 && load_words <= 128) begin
                    m_phase = 1; m_bytes.delete(); m_words = load_words;
                    m_idle = 0; e_iwen = 1; e_busy = 1; e_done = 0; e_error = 0;
                    e_addr = '0; e_winst = '0; e_csum = '0;
                end else begin
                    m_phase = 4; e_error = 1; e_done = 0;
                end
            end
            1: if (rx_valid) begin
                m_bytes.push_back(rx_data);
                m_idle = 0;
                s = 0;
                foreach (m_bytes[i]) s += m_bytes[i];
                e_csum = 8'(s % 256);
                if (m_bytes.size() % 4 == 0) begin
                    k = m_bytes.size() / 4 - 1;
                    e_addr = 7'(k);
                    e_winst = {m_bytes[4*k], m_bytes[4*k+1],
                               m_bytes[4*k+2], m_bytes[4*k+3]};
                    if (k == m_words - 1) begin
                        m_phase = 2; m_settle = 2;
                    end
                end
            end else begin
                m_idle++;
                if (m_idle == 1023) begin
                    m_phase = 4; e_iwen = 0; e_busy = 0; e_error = 1;
                end
            end
            2: begin
                m_settle--;
                if (m_settle == 0) begin
                    m_phase = 3; e_iwen = 0; e_busy = 0; e_done = 1;
                end
            end
            default: ;
        endcase
    endtask

    // inputs change #1 after posedge, so at negedge they are what the next edge sees
    always @(negedge clk) begin
        if (!rst) model_reset();
        chk("iwen", 32'(IWEN), 32'(e_iwen));
        chk("ready", 32'(rx_ready), 32'(m_phase == 1));
        chk("addr", 32'(I_Addr), 32'(e_addr));
        chk("winst", wInst, e_winst);
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        chk("error", 32'(error), 32'(e_error));
        chk("csum", 32'(checksum), 32'(e_csum));
        if (rst) model_step();
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input logic [7:0] w);
        start = 1'b1; load_words = w;
        tick(1);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        rx_valid = 1'b0;
        tick(gap);
        rx_valid = 1'b1; rx_data = b;
        tick(1);
        rx_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        tick(3);
        rst = 1'b1;
        tick(1);
        chk("rst_iwen", 32'(IWEN), 32'd0);
        chk("rst_winst", wInst, 32'd0);

        // single word, back-to-back
        pulse_start(8'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        send(8'h13, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
        chk("t1_winst", wInst, 32'h13000000);
        chk("t1_model", e_winst, 32'h13000000);
        chk("t1_iwen_a", 32'(IWEN), 32'd1);
        tick(1);
        chk("t1_iwen_b", 32'(IWEN), 32'd1);
        tick(1);
        chk("t1_iwen_off", 32'(IWEN), 32'd0);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_csum", 32'(checksum), 32'h13);

        // bad word counts
        pulse_start(8'd0);
        chk("t4_err0", 32'(error), 32'd1);
        chk("t4_done0", 32'(done), 32'd0);
        chk("t4_iwen0", 32'(IWEN), 32'd0);
        pulse_start(8'd200);
        chk("t4_err200", 32'(error), 32'd1);
        chk("t4_iwen200", 32'(IWEN), 32'd0);

        // full depth with gaps
        pulse_start(8'd128);
        for (int i = 0; i < 512; i++) send(8'((i * 7 + 3) & 255), i % 6);
        chk("t2_addr", 32'(I_Addr), 32'd127);
        chk("t2_winst", wInst, 32'hE7EEF5FC);
        chk("t2_model", e_winst, 32'hE7EEF5FC);
        tick(2);
        chk("t2_done", 32'(done), 32'd1);

        // timeout after 5 bytes
        pulse_start(8'd2);
        for (int i = 1; i <= 5; i++) send(8'(i), 0);
        tick(1022);
        chk("t3_early", 32'(error), 32'd0);
        tick(1);
        chk("t3_error", 32'(error), 32'd1);
        chk("t3_iwen", 32'(IWEN), 32'd0);
        chk("t3_addr", 32'(I_Addr), 32'd0);
        chk("t3_winst", wInst, 32'h01020304);

        // reset mid-load
        pulse_start(8'd4);
        for (int i = 0; i < 6; i++) send(8'(8'h40 + i), 1);
        chk("t5_pre", wInst, 32'h40414243);
        rst = 1'b0;
        #1;
        chk("t5_iwen", 32'(IWEN), 32'd0);
        chk("t5_winst", wInst, 32'd0);
        chk("t5_csum", 32'(checksum), 32'd0);
        tick(2);
        rst = 1'b1;
        tick(1);

        // bytes in IDLE and start pulses in LOAD are ignored
        rx_valid = 1'b1; rx_data = 8'hFF;
        tick(3);
        chk("t6_ready", 32'(rx_ready), 32'd0);
        rx_valid = 1'b0;
        chk("t6_csum", 32'(checksum), 32'd0);
        pulse_start(8'd1);
        send(8'hAA, 0);
        pulse_start(8'd0);
        send(8'hBB, 1);
        chk("t6_noerr", 32'(error), 32'd0);
        send(8'hCC, 0); send(8'hDD, 2);
        chk("t6_winst", wInst, 32'hAABBCCDD);
        chk("t6_addr", 32'(I_Addr), 32'd0);
        chk("t6_csum2", 32'(checksum), 32'h0E);
        tick(2);
        chk("t6_done", 32'(done), 32'd1);
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
